// File: rtl/vector_core_if.sv
// Command/result channel of vector_core: valid/ready command side, valid/yumi result side.
interface vector_core_if #(
    parameter int els_p  = 32,
    parameter int vlen_p = 8,
    parameter int vdw_p  = 8
);
    localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int vl_w_lp   = $clog2(vlen_p + 1);

    logic                      v_i;
    logic                      ready_o;
    logic [3:0]                op_i;
    logic [addr_w_lp-1:0]      addr_a_i;
    logic [addr_w_lp-1:0]      addr_b_i;
    logic [addr_w_lp-1:0]      addr_c_i;
    logic [vdw_p-1:0]          scalar_i;
    logic [vl_w_lp-1:0]        vl_i;
    logic [vlen_p*vdw_p-1:0]   w_data_i;
    logic                      v_o;
    logic                      yumi_i;
    logic [vlen_p*vdw_p-1:0]   r_data_o;
    logic                      err_o;

    modport master (
        output v_i, op_i, addr_a_i, addr_b_i, addr_c_i, scalar_i, vl_i, w_data_i, yumi_i,
        input  ready_o, v_o, r_data_o, err_o
    );

    modport slave (
        input  v_i, op_i, addr_a_i, addr_b_i, addr_c_i, scalar_i, vl_i, w_data_i, yumi_i,
        output ready_o, v_o, r_data_o, err_o
    );
endinterface

// File: rtl/vector_core.sv
// Vector register file with a lane-parallel ALU, processing lanes_p elements per BUSY beat.
// Optional saturating arithmetic is enabled by defining VECTOR_CORE_SAT_EN.
module vector_core #(
    parameter int els_p   = 32,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 8,
    parameter int lanes_p = 4
) (
    input logic          clk_i,
    input logic          reset_i,
    vector_core_if.slave cmd
);
    localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int vl_w_lp   = $clog2(vlen_p + 1);
    localparam int idx_w_lp  = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int beat_w_lp = $clog2(vlen_p / lanes_p + 1);
    localparam int row_w_lp  = vlen_p * vdw_p;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        BUSY_S = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t                            state_r;
    state_t                            state_nxt_s;
    logic [3:0]                        op_r;
    logic [addr_w_lp-1:0]              a_r;
    logic [addr_w_lp-1:0]              b_r;
    logic [addr_w_lp-1:0]              c_r;
    logic [vdw_p-1:0]                  scalar_r;
    logic [vl_w_lp-1:0]                vl_r;
    logic [vl_w_lp-1:0]                vl_clamp_s;
    logic [row_w_lp-1:0]               wdata_r;
    logic [row_w_lp-1:0]               r_data_r;
    logic                              err_r;
    logic [beat_w_lp-1:0]              beat_r;
    logic [els_p-1:0][row_w_lp-1:0]    rf_r;
    logic                              legal_in_s;
    logic                              last_beat_s;
    logic [lanes_p-1:0][idx_w_lp-1:0]  lane_idx_s;
    logic [lanes_p-1:0]                lane_en_s;
    logic [lanes_p-1:0][vdw_p-1:0]     lane_res_s;

    function automatic logic legal_f(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1001: legal_f = 1'b1;
            default:          legal_f = 1'b0;
        endcase
    endfunction

    // kind: 00 add, 01 sub, 10 mult
    function automatic logic [vdw_p-1:0] alu_f(input logic [1:0] kind,
                                               input logic [vdw_p-1:0] x,
                                               input logic [vdw_p-1:0] y);
`ifdef VECTOR_CORE_SAT_EN
        logic [vdw_p:0]     sum;
        logic [vdw_p:0]     diff;
        logic [2*vdw_p-1:0] prod;
        sum  = {1'b0, x} + {1'b0, y};
        diff = {1'b0, x} - {1'b0, y};
        prod = x * y;
        case (kind)
            2'b00:   alu_f = sum[vdw_p] ? {vdw_p{1'b1}} : sum[vdw_p-1:0];
            2'b01:   alu_f = diff[vdw_p] ? {vdw_p{1'b0}} : diff[vdw_p-1:0];
            2'b10:   alu_f = (|prod[2*vdw_p-1:vdw_p]) ? {vdw_p{1'b1}} : prod[vdw_p-1:0];
            default: alu_f = {vdw_p{1'b0}};
        endcase
`else
        case (kind)
            2'b00:   alu_f = x + y;
            2'b01:   alu_f = x - y;
            2'b10:   alu_f = x * y;
            default: alu_f = {vdw_p{1'b0}};
        endcase
`endif
    endfunction

    // Classify the incoming command and clamp its vector length
    always_comb begin
        legal_in_s = legal_f(cmd.op_i);
        if (int'(cmd.vl_i) > vlen_p) begin
            vl_clamp_s = vl_w_lp'(vlen_p);
        end else begin
            vl_clamp_s = cmd.vl_i;
        end
    end

    // Per-lane element index, enable and ALU result for the current beat
    always_comb begin
        lane_idx_s  = '0;
        lane_en_s   = '0;
        lane_res_s  = '0;
        last_beat_s = ((int'(beat_r) + 1) * lanes_p) >= int'(vl_r);
        for (int l = 0; l < lanes_p; l++) begin
            lane_idx_s[l] = idx_w_lp'(int'(beat_r) * lanes_p + l);
            lane_en_s[l]  = (int'(beat_r) * lanes_p + l) < int'(vl_r);
            lane_res_s[l] = alu_f(op_r[1:0], rf_r[a_r][lane_idx_s[l]*vdw_p +: vdw_p],
                                  op_r[2] ? scalar_r : rf_r[b_r][lane_idx_s[l]*vdw_p +: vdw_p]);
        end
    end

    // Next-state logic; zero-length and illegal commands skip BUSY
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE_S: begin
                if (cmd.v_i) begin
                    if (legal_in_s && (vl_clamp_s != {vl_w_lp{1'b0}})) begin
                        state_nxt_s = BUSY_S;
                    end else begin
                        state_nxt_s = DONE_S;
                    end
                end else begin
                    state_nxt_s = IDLE_S;
                end
            end
            BUSY_S: begin
                if (last_beat_s) begin
                    state_nxt_s = DONE_S;
                end else begin
                    state_nxt_s = BUSY_S;
                end
            end
            DONE_S: begin
                if (cmd.yumi_i) begin
                    state_nxt_s = IDLE_S;
                end else begin
                    state_nxt_s = DONE_S;
                end
            end
            default: state_nxt_s = IDLE_S;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE_S;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command capture, beat execution and register file update
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rf_r     <= '0;
            op_r     <= 4'b0000;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            scalar_r <= '0;
            vl_r     <= '0;
            wdata_r  <= '0;
            r_data_r <= '0;
            err_r    <= 1'b0;
            beat_r   <= '0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    if (cmd.v_i) begin
                        op_r     <= cmd.op_i;
                        a_r      <= cmd.addr_a_i;
                        b_r      <= cmd.addr_b_i;
                        c_r      <= cmd.addr_c_i;
                        scalar_r <= cmd.scalar_i;
                        vl_r     <= vl_clamp_s;
                        wdata_r  <= cmd.w_data_i;
                        r_data_r <= '0;
                        err_r    <= ~legal_in_s;
                        beat_r   <= '0;
                    end
                end
                BUSY_S: begin
                    beat_r <= beat_r + beat_w_lp'(1);
                    // Only legal ops reach BUSY, so op_r[3]/op_r[0] fully decode read vs write
                    for (int l = 0; l < lanes_p; l++) begin
                        if (lane_en_s[l]) begin
                            if (!op_r[3]) begin
                                rf_r[c_r][lane_idx_s[l]*vdw_p +: vdw_p] <= lane_res_s[l];
                            end else if (!op_r[0]) begin
                                r_data_r[lane_idx_s[l]*vdw_p +: vdw_p] <=
                                    rf_r[a_r][lane_idx_s[l]*vdw_p +: vdw_p];
                            end else begin
                                rf_r[c_r][lane_idx_s[l]*vdw_p +: vdw_p] <=
                                    wdata_r[lane_idx_s[l]*vdw_p +: vdw_p];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd.ready_o  = (state_r == IDLE_S);
    assign cmd.v_o      = (state_r == DONE_S);
    assign cmd.r_data_o = r_data_r;
    assign cmd.err_o    = err_r;
endmodule

// File: tb/tb_vector_core.sv
// Self-checking bench for vector_core: directed scenarios plus random commands against an array model.
module tb_vector_core;
    localparam int ELS   = 32;
    localparam int VLEN  = 8;
    localparam int VDW   = 8;
    localparam int LANES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_core_if #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW)) bus ();
    vector_core #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .cmd    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_rf [ELS][VLEN];
    logic [63:0] rd;
    int          lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [3:0] op);
        return (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9});
    endfunction

    function automatic logic [7:0] m_arith(input logic [1:0] k, input int x, input int y);
        int r;
        case (k)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            default: r = x * y;
        endcase
`ifdef VECTOR_CORE_SAT_EN
        if (r > 255) r = 255;
        if (r < 0) r = 0;
`else
        r = ((r % 256) + 256) % 256;
`endif
        return 8'(r);
    endfunction

    task automatic m_clear();
        for (int e = 0; e < ELS; e++)
            for (int i = 0; i < VLEN; i++) m_rf[e][i] = 8'h00;
    endtask

    // Issue one command, check latency/result/err/hold stability, then consume it.
    task automatic run_cmd(input logic [3:0] op, input int a, input int b, input int c,
                           input logic [7:0] sc, input int vl, input logic [63:0] wd,
                           input int hold, output logic [63:0] rd_o, output int lat_o);
        int          vle;
        int          exp_lat;
        logic [63:0] exp_rd;
        bit          legal;
        int          cyc;
        legal   = m_legal(op);
        vle     = (vl > VLEN) ? VLEN : vl;
        exp_lat = legal ? ((vle + LANES - 1) / LANES + 1) : 1;
        exp_rd  = 64'h0;
        if (legal) begin
            for (int i = 0; i < vle; i++) begin
                if (op == 4'd8) exp_rd[i*8 +: 8] = m_rf[a][i];
                else if (op == 4'd9) m_rf[c][i] = wd[i*8 +: 8];
                else m_rf[c][i] = m_arith(op[1:0], int'(m_rf[a][i]),
                                          op[2] ? int'(sc) : int'(m_rf[b][i]));
            end
        end
        @(negedge clk);
        chk("ready_idle", 64'(bus.ready_o), 64'd1);
        bus.v_i      = 1'b1;
        bus.op_i     = op;
        bus.addr_a_i = 5'(a);
        bus.addr_b_i = 5'(b);
        bus.addr_c_i = 5'(c);
        bus.scalar_i = sc;
        bus.vl_i     = 4'(vl);
        bus.w_data_i = wd;
        @(negedge clk);
        bus.v_i      = 1'b0;
        bus.op_i     = 4'hF;
        bus.w_data_i = ~wd;
        bus.scalar_i = ~sc;
        cyc = 1;
        while (bus.v_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("err", 64'(bus.err_o), 64'(!legal));
        chk("r_data", bus.r_data_o, exp_rd);
        rd_o  = bus.r_data_o;
        lat_o = cyc;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_v", 64'(bus.v_o), 64'd1);
            chk("hold_err", 64'(bus.err_o), 64'(!legal));
            chk("hold_rdata", bus.r_data_o, exp_rd);
        end
        bus.yumi_i = 1'b1;
        @(negedge clk);
        bus.yumi_i = 1'b0;
        chk("post_yumi_v", 64'(bus.v_o), 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] exp_mul;
        logic [7:0] exp_sub;
        bus.v_i = 1'b0; bus.yumi_i = 1'b0; bus.op_i = 4'h0; bus.scalar_i = 8'h00;
        bus.addr_a_i = 5'd0; bus.addr_b_i = 5'd0; bus.addr_c_i = 5'd0;
        bus.vl_i = 4'd0; bus.w_data_i = 64'h0;
        m_clear();
        #1;
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_v", 64'(bus.v_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        chk("rst_rdata", bus.r_data_o, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_cmd(4'd9, 0, 0, 3, 8'h00, 8, 64'h0807060504030201, 0, rd, lat);
        chk("write_lat", 64'(lat), 64'd3);
        run_cmd(4'd8, 3, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);
        chk("read_v3", rd, 64'h0807060504030201);

        run_cmd(4'd0, 3, 3, 3, 8'h00, 8, 64'h0, 0, rd, lat);
        run_cmd(4'd8, 3, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);
        chk("inplace_add", rd, 64'h100E0C0A08060402);

        run_cmd(4'd9, 0, 0, 7, 8'h00, 8, 64'hFFFFFFFFFFFFFFFF, 0, rd, lat);
        run_cmd(4'd9, 0, 0, 7, 8'h00, 5, 64'h0, 0, rd, lat);
        run_cmd(4'd8, 7, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);
        chk("partial_write", rd, 64'hFFFFFF0000000000);
        run_cmd(4'd8, 7, 0, 0, 8'h00, 5, 64'h0, 0, rd, lat);
        chk("partial_read", rd, 64'h0);

`ifdef VECTOR_CORE_SAT_EN
        exp_mul = 8'hFF; exp_sub = 8'h00;
`else
        exp_mul = 8'h40; exp_sub = 8'hFF;
`endif
        run_cmd(4'd9, 0, 0, 1, 8'h00, 8, 64'h05, 0, rd, lat);
        run_cmd(4'd6, 1, 0, 2, 8'h40, 1, 64'h0, 0, rd, lat);
        run_cmd(4'd8, 2, 0, 0, 8'h00, 1, 64'h0, 0, rd, lat);
        chk("mul_scalar", rd, {56'h0, exp_mul});
        run_cmd(4'd9, 0, 0, 4, 8'h00, 8, 64'h01, 0, rd, lat);
        run_cmd(4'd5, 4, 0, 5, 8'h02, 1, 64'h0, 0, rd, lat);
        run_cmd(4'd8, 5, 0, 0, 8'h00, 1, 64'h0, 0, rd, lat);
        chk("sub_scalar", rd, {56'h0, exp_sub});

        run_cmd(4'd3, 3, 3, 3, 8'h11, 8, 64'hFFFFFFFFFFFFFFFF, 5, rd, lat);
        chk("illegal_lat", 64'(lat), 64'd1);
        run_cmd(4'd8, 3, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);
        chk("illegal_nowrite", rd, 64'h100E0C0A08060402);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 4'($urandom_range(0, 15));
            end else begin
                case ($urandom_range(0, 7))
                    0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd4;
                    4: op = 4'd5; 5: op = 4'd6; 6: op = 4'd8; default: op = 4'd9;
                endcase
            end
            run_cmd(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    8'($urandom), $urandom_range(0, 15), {$urandom, $urandom},
                    $urandom_range(0, 2), rd, lat);
        end
        for (int r = 0; r < 8; r++)
            run_cmd(4'd8, r, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);

        @(negedge clk);
        bus.v_i = 1'b1; bus.op_i = 4'd0; bus.addr_a_i = 5'd1; bus.addr_b_i = 5'd2;
        bus.addr_c_i = 5'd3; bus.vl_i = 4'd8;
        @(negedge clk);
        bus.v_i = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_ready", 64'(bus.ready_o), 64'd1);
        chk("abort_v", 64'(bus.v_o), 64'd0);
        chk("abort_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_clear();
        for (int r = 0; r < ELS; r++)
            run_cmd(4'd8, r, 0, 0, 8'h00, 8, 64'h0, 0, rd, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
